hazard_ctrl: RTL and testbench

//  Pipeline hazard controller for the 5-stage core. It decides stall/flush for the
//  PC, IF/ID and ID/EX pipeline registers, and drives EX operand forwarding selects.
//  It freezes the whole pipe while a data-memory access awaits ack, and counts stall cycles.

---
 rtl/hazard_ctrl_pkg.sv | 7 +
 rtl/hazard_ctrl_fwd_sel.sv | 15 +
 rtl/hazard_ctrl.sv | 76 +++++++
 tb/tb_hazard_ctrl.sv | 129 ++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared forwarding-select codes and controller state encoding.
package hazard_ctrl_pkg;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  typedef enum logic {HC_RUN, HC_MEM_WAIT} hc_state_e;
endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// hazard_ctrl_fwd_sel: picks the EX operand source; MEM wins over WB, register 0 never forwards.
module hazard_ctrl_fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] ex_src,
  input  logic [4:0] mem_dst,
  input  logic       mem_w_reg_ena,
  input  logic [4:0] wb_dst,
  input  logic       wb_w_reg_ena,
  output logic [1:0] fwd
);
  always_comb
    fwd = (mem_w_reg_ena && mem_dst != 5'd0 && mem_dst == ex_src) ? FWD_MEM :
          (wb_w_reg_ena && wb_dst != 5'd0 && wb_dst == ex_src)    ? FWD_WB  : FWD_RF;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forwarding control for the 5-stage pipe, with a
// data-memory freeze FSM, ack timeout flag and saturating stall counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_br_taken,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       ex_dst,
  input  logic             ex_w_reg_ena,
  input  logic             ex_mem_r,
  input  logic [4:0]       mem_dst,
  input  logic             mem_w_reg_ena,
  input  logic [4:0]       wb_dst,
  input  logic             wb_w_reg_ena,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             stall_id_ex,
  output logic             stall_ex_mem,
  output logic             clear_if_id,
  output logic             clear_id_ex,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             err_timeout
);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [WW-1:0] WAIT_LIM = WW'(TIMEOUT - 1);
  hc_state_e state, state_nxt;
  logic [WW-1:0] wait_cnt;
  logic freeze, load_use, waiting;
  logic [1:0] fa, fb;
  hazard_ctrl_fwd_sel u_fwd_a (.ex_src(ex_rs), .mem_dst(mem_dst), .mem_w_reg_ena(mem_w_reg_ena),
                               .wb_dst(wb_dst), .wb_w_reg_ena(wb_w_reg_ena), .fwd(fa));
  hazard_ctrl_fwd_sel u_fwd_b (.ex_src(ex_rt), .mem_dst(mem_dst), .mem_w_reg_ena(mem_w_reg_ena),
                               .wb_dst(wb_dst), .wb_w_reg_ena(wb_w_reg_ena), .fwd(fb));
  // Outputs are gated by rst so the stage regs see no stall/clear while reset is held.
  always_comb begin
    freeze       = dmem_req & ~dmem_ack;
    load_use     = ex_mem_r & ex_w_reg_ena & (ex_dst != 5'd0) &
                   ((id_use_rs & (id_rs == ex_dst)) | (id_use_rt & (id_rt == ex_dst)));
    waiting      = (state == HC_MEM_WAIT) & ~dmem_ack;
    state_nxt    = (state == HC_RUN) ? (freeze ? HC_MEM_WAIT : HC_RUN) : (dmem_ack ? HC_RUN : HC_MEM_WAIT);
    stall_pc     = rst & (freeze | load_use);
    stall_if_id  = rst & (freeze | load_use);
    stall_id_ex  = rst & freeze;
    stall_ex_mem = rst & freeze;
    clear_id_ex  = rst & ~freeze & load_use;
    clear_if_id  = rst & ~freeze & ~load_use & id_br_taken;
    fwd_a        = rst ? fa : FWD_RF;
    fwd_b        = rst ? fb : FWD_RF;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state       <= HC_RUN;
      wait_cnt    <= '0;
      stall_cnt   <= '0;
      err_timeout <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= waiting ? ((wait_cnt == WAIT_LIM) ? wait_cnt : wait_cnt + 1'b1) : '0;
      if (waiting && wait_cnt == WAIT_LIM) err_timeout <= 1'b1;
      if (stall_pc && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed hazard scenarios then random traffic, checked against
// a cycle-level behavioural model of the stall/flush/forward rules.
module tb_hazard_ctrl;
  localparam int TO = 4;
  localparam int CW = 2;
  logic clk = 1'b0, rst = 1'b0;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_dst, mem_dst, wb_dst;
  logic id_use_rs, id_use_rt, id_br_taken, ex_w_reg_ena, ex_mem_r;
  logic mem_w_reg_ena, wb_w_reg_ena, dmem_req, dmem_ack;
  logic stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, clear_if_id, clear_id_ex, err_timeout;
  logic [1:0] fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt;
  int compared = 0, mismatched = 0;
  bit m_wait = 0, m_err = 0;
  int m_waited = 0, m_cnt = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_br_taken(id_br_taken), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst), .ex_w_reg_ena(ex_w_reg_ena),
    .ex_mem_r(ex_mem_r), .mem_dst(mem_dst), .mem_w_reg_ena(mem_w_reg_ena), .wb_dst(wb_dst),
    .wb_w_reg_ena(wb_w_reg_ena), .dmem_req(dmem_req), .dmem_ack(dmem_ack), .stall_pc(stall_pc),
    .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex), .stall_ex_mem(stall_ex_mem),
    .clear_if_id(clear_if_id), .clear_id_ex(clear_id_ex), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .err_timeout(err_timeout));

  task automatic chk(input string tag, input logic [31:0] obs, input int exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int fwd_of(input logic [4:0] src);
    if (mem_w_reg_ena && mem_dst != 0 && mem_dst == src) return 2;
    if (wb_w_reg_ena && wb_dst != 0 && wb_dst == src) return 1;
    return 0;
  endfunction

  task automatic clr();
    {id_rs, id_rt, ex_rs, ex_rt, ex_dst, mem_dst, wb_dst} = '0;
    {id_use_rs, id_use_rt, id_br_taken, ex_w_reg_ena, ex_mem_r} = '0;
    {mem_w_reg_ena, wb_w_reg_ena, dmem_req, dmem_ack} = '0;
  endtask

  task automatic load_use_setup(input logic [4:0] r);
    ex_mem_r = 1; ex_w_reg_ena = 1; ex_dst = r; id_use_rs = 1; id_rs = r;
  endtask

  task automatic reset_check(input string tag);
    m_wait = 0; m_err = 0; m_waited = 0; m_cnt = 0;
    chk({tag, ".stall_pc"}, stall_pc, 0);
    chk({tag, ".stall_if_id"}, stall_if_id, 0);
    chk({tag, ".stall_id_ex"}, stall_id_ex, 0);
    chk({tag, ".stall_ex_mem"}, stall_ex_mem, 0);
    chk({tag, ".clear_if_id"}, clear_if_id, 0);
    chk({tag, ".clear_id_ex"}, clear_id_ex, 0);
    chk({tag, ".fwd_a"}, fwd_a, 0);
    chk({tag, ".fwd_b"}, fwd_b, 0);
    chk({tag, ".stall_cnt"}, stall_cnt, 0);
    chk({tag, ".err_timeout"}, err_timeout, 0);
  endtask

  // Called just after a falling edge with inputs set; checks, clocks, advances the model.
  task automatic step(input string tag);
    bit fr, lu;
    #1;
    fr = dmem_req && !dmem_ack;
    lu = ex_mem_r && ex_w_reg_ena && ex_dst != 0 &&
         ((id_use_rs && id_rs == ex_dst) || (id_use_rt && id_rt == ex_dst));
    chk({tag, ".stall_pc"}, stall_pc, int'(fr || lu));
    chk({tag, ".stall_if_id"}, stall_if_id, int'(fr || lu));
    chk({tag, ".stall_id_ex"}, stall_id_ex, int'(fr));
    chk({tag, ".stall_ex_mem"}, stall_ex_mem, int'(fr));
    chk({tag, ".clear_id_ex"}, clear_id_ex, int'(!fr && lu));
    chk({tag, ".clear_if_id"}, clear_if_id, int'(!fr && !lu && id_br_taken));
    chk({tag, ".fwd_a"}, fwd_a, fwd_of(ex_rs));
    chk({tag, ".fwd_b"}, fwd_b, fwd_of(ex_rt));
    chk({tag, ".stall_cnt"}, stall_cnt, m_cnt);
    chk({tag, ".err_timeout"}, err_timeout, int'(m_err));
    @(posedge clk);
    if (fr || lu) m_cnt = (m_cnt + 1 > 2 ** CW - 1) ? 2 ** CW - 1 : m_cnt + 1;
    if (m_wait) begin
      if (dmem_ack) begin m_wait = 0; m_waited = 0; end
      else begin m_waited++; if (m_waited >= TO) m_err = 1; end
    end else if (fr) m_wait = 1;
    @(negedge clk);
  endtask

  initial begin
    clr();
    load_use_setup(5'd2); dmem_req = 1; id_br_taken = 1;
    mem_w_reg_ena = 1; mem_dst = 5'd3; ex_rs = 5'd3; ex_rt = 5'd3;
    #2 reset_check("rst_hold");
    @(negedge clk); rst = 1; clr();
    load_use_setup(5'd2); id_rt = 5'd7; step("t1_lu");
    clr(); step("t1_after");
    ex_mem_r = 1; ex_w_reg_ena = 1; ex_dst = 0; id_use_rs = 1; id_rs = 0;
    mem_w_reg_ena = 1; mem_dst = 5; wb_w_reg_ena = 1; wb_dst = 5; ex_rs = 5; ex_rt = 0; step("t2_mem_wb");
    mem_w_reg_ena = 0; ex_rt = 5; step("t2_wb_only");
    clr(); id_br_taken = 1; step("t3_br");
    load_use_setup(5'd9); id_br_taken = 1; step("t3_br_lu");
    clr(); dmem_req = 1; id_br_taken = 1; load_use_setup(5'd4);
    step("t4_w0"); step("t4_w1"); step("t4_w2");
    dmem_ack = 1; step("t4_ack");
    clr(); step("t4_run");
    dmem_req = 1;
    for (int i = 0; i < TO + 2; i++) step($sformatf("t5_w%0d", i));
    dmem_ack = 1; step("t5_ack");
    clr(); step("t5_sticky");
    dmem_req = 1; step("t6_w0"); step("t6_w1");
    #2 rst = 0;
    #1 reset_check("t6_rst");
    @(negedge clk); rst = 1; clr(); step("t6_run");
    for (int i = 0; i < 300; i++) begin
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      ex_rs = 5'($urandom_range(0, 3)); ex_rt = 5'($urandom_range(0, 3));
      ex_dst = 5'($urandom_range(0, 3)); mem_dst = 5'($urandom_range(0, 3)); wb_dst = 5'($urandom_range(0, 3));
      {id_use_rs, id_use_rt, id_br_taken, ex_w_reg_ena, ex_mem_r, mem_w_reg_ena, wb_w_reg_ena} = 7'($urandom);
      dmem_req = ($urandom_range(0, 3) == 0);
      dmem_ack = ($urandom_range(0, 2) == 0);
      step($sformatf("rnd%0d", i));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
